// File: rtl/iwrite_controller_mid_pe.sv
// Round-robin activation writer into ping-pong BRAM halves for a mid-array PE.
// Define IWRITE_LAST_CHECK_EN to add the sticky err_last stream-framing check.
module iwrite_controller_mid_pe #(
  parameter  int NUM_BANKS    = 4,
  parameter  int WRITE_DEPTH  = 512,
  parameter  int STREAM_WIDTH = 64,
  parameter  int MAX_FILLS    = 256,
  localparam int AW = $clog2(WRITE_DEPTH) + 1,
  localparam int FW = $clog2(MAX_FILLS) + 1,
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AW-1:0]           cfg_words_per_bank,
  input  logic [FW-1:0]           cfg_num_fills,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [STREAM_WIDTH-1:0] act_stream_data,
  input  logic                    act_stream_valid,
  output logic                    act_stream_ready,
  input  logic                    act_stream_last,
  output logic [NUM_BANKS-1:0]    enaA,
  output logic [NUM_BANKS-1:0]    weA,
  output logic [AW-1:0]           addrA_ping_pong,
  output logic [STREAM_WIDTH-1:0] diA,
  output logic [NUM_BANKS*AW-1:0] write_addr_pingpong_data,
  input  logic                    rd_buf_release,
  output logic [1:0]              buf_full,
  output logic                    err_cfg,
  output logic                    err_release
`ifdef IWRITE_LAST_CHECK_EN
  ,
  output logic                    err_last
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUF,
    WRITE,
    COMMIT
  } state_t;

  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

  state_t state_q, state_d;

  logic          pp_q;
  logic          rd_ptr_q;
  logic [1:0]    full_q, full_d;
  logic [BW-1:0] bank_q;
  logic [AW-2:0] word_q;
  logic [FW-1:0] fill_q;
  logic [AW-1:0] words_q;
  logic [FW-1:0] fills_q;
  logic          wr_v_q;
  logic [BW-1:0] wr_bank_q;
  logic [AW-2:0] cnt_q [NUM_BANKS];

  logic                 cfg_ok;
  logic                 rel_ok;
  logic                 beat;
  logic                 last_beat;
  logic                 commit;
  logic                 half_free;
  logic                 fill_done;
  logic [NUM_BANKS-1:0] bank_oh;

  assign cfg_ok = (cfg_words_per_bank != '0)
                & (cfg_words_per_bank <= AW'(WRITE_DEPTH))
                & (cfg_num_fills != '0)
                & (cfg_num_fills <= FW'(MAX_FILLS));

  assign rel_ok    = rd_buf_release & full_q[rd_ptr_q];
  assign beat      = (state_q == WRITE) & act_stream_valid;
  assign last_beat = (bank_q == LAST_BANK)
                   & ({1'b0, word_q} == words_q - 1'b1);
  assign commit    = (state_q == COMMIT);
  assign fill_done = ((fill_q + 1'b1) == fills_q);

  // A release of the half we are waiting on frees it this cycle.
  assign half_free = ~full_q[pp_q] | (rel_ok & (rd_ptr_q == pp_q));

  assign cfg_ready        = (state_q == IDLE);
  assign act_stream_ready = (state_q == WRITE);
  assign buf_full         = full_q;

  always_comb begin
    bank_oh         = '0;
    bank_oh[bank_q] = 1'b1;
  end

  always_comb begin
    full_d = full_q;
    if (commit) full_d[pp_q] = 1'b1;
    if (rel_ok) full_d[rd_ptr_q] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (cfg_valid && cfg_ok) state_d = WAIT_BUF;
      WAIT_BUF: if (half_free) state_d = WRITE;
      WRITE:    if (beat && last_beat) state_d = COMMIT;
      COMMIT:   state_d = fill_done ? IDLE : WAIT_BUF;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      full_q      <= '0;
      pp_q        <= 1'b0;
      rd_ptr_q    <= 1'b0;
      bank_q      <= '0;
      word_q      <= '0;
      fill_q      <= '0;
      words_q     <= '0;
      fills_q     <= '0;
      err_cfg     <= 1'b0;
      err_release <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      if (rel_ok) rd_ptr_q <= ~rd_ptr_q;
      if (rd_buf_release && !full_q[rd_ptr_q]) err_release <= 1'b1;
      if (state_q == IDLE && cfg_valid) begin
        if (cfg_ok) begin
          words_q <= cfg_words_per_bank;
          fills_q <= cfg_num_fills;
          fill_q  <= '0;
        end else begin
          err_cfg <= 1'b1;
        end
      end
      if (beat) begin
        if (bank_q == LAST_BANK) begin
          bank_q <= '0;
          word_q <= word_q + 1'b1;
        end else begin
          bank_q <= bank_q + 1'b1;
        end
      end
      if (commit) begin
        pp_q   <= ~pp_q;
        bank_q <= '0;
        word_q <= '0;
        fill_q <= fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      enaA            <= '0;
      weA             <= '0;
      addrA_ping_pong <= '0;
      diA             <= '0;
      wr_v_q          <= 1'b0;
      wr_bank_q       <= '0;
    end else begin
      enaA      <= beat ? bank_oh : '0;
      weA       <= beat ? bank_oh : '0;
      wr_v_q    <= beat;
      wr_bank_q <= bank_q;
      if (beat) begin
        addrA_ping_pong <= {word_q, pp_q};
        diA             <= act_stream_data;
      end
    end
  end

  // Counts trail the BRAM write by one cycle; commit restarts them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) cnt_q[b] <= '0;
    end else if (commit) begin
      for (int b = 0; b < NUM_BANKS; b++) cnt_q[b] <= '0;
    end else if (wr_v_q) begin
      cnt_q[wr_bank_q] <= cnt_q[wr_bank_q] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_ptr
    assign write_addr_pingpong_data[g*AW +: AW] = {pp_q, cnt_q[g]};
  end

`ifdef IWRITE_LAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst_n) err_last <= 1'b0;
    else if (beat && (act_stream_last != last_beat)) err_last <= 1'b1;
  end
`else
  logic unused_last;
  assign unused_last = act_stream_last;
`endif

endmodule

// File: tb/tb_iwrite_controller_mid_pe.sv
// Randomized bench for iwrite_controller_mid_pe with a beat-index reference model.
// Builds with or without IWRITE_LAST_CHECK_EN.
module tb_iwrite_controller_mid_pe;
  localparam int NB = 4;
  localparam int WD = 512;
  localparam int SW = 64;
  localparam int MF = 256;
  localparam int AW = $clog2(WD) + 1;
  localparam int FW = $clog2(MF) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] cfg_words_per_bank = '0;
  logic [FW-1:0] cfg_num_fills = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [SW-1:0] act_stream_data = '0;
  logic          act_stream_valid = 1'b0;
  logic          act_stream_ready;
  logic          act_stream_last = 1'b0;
  logic [NB-1:0] enaA, weA;
  logic [AW-1:0] addrA_ping_pong;
  logic [SW-1:0] diA;
  logic [NB*AW-1:0] write_addr_pingpong_data;
  logic          rd_buf_release = 1'b0;
  logic [1:0]    buf_full;
  logic          err_cfg, err_release;
`ifdef IWRITE_LAST_CHECK_EN
  logic          err_last;
`endif

  iwrite_controller_mid_pe dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_words_per_bank(cfg_words_per_bank),
    .cfg_num_fills(cfg_num_fills),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .act_stream_data(act_stream_data),
    .act_stream_valid(act_stream_valid),
    .act_stream_ready(act_stream_ready),
    .act_stream_last(act_stream_last),
    .enaA(enaA), .weA(weA),
    .addrA_ping_pong(addrA_ping_pong), .diA(diA),
    .write_addr_pingpong_data(write_addr_pingpong_data),
    .rd_buf_release(rd_buf_release),
    .buf_full(buf_full),
    .err_cfg(err_cfg), .err_release(err_release)
`ifdef IWRITE_LAST_CHECK_EN
    , .err_last(err_last)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            bank;
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
    int            cyc;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [NB-1:0] mon_oh;
  int   cyc;
  int   total, bad;
  bit   m_pp, m_rd, m_err_rel;
  bit [1:0] m_full;

  always @(posedge clk) cyc <= cyc + 1;

  // Every BRAM write must match the oldest accepted beat, one cycle later.
  always @(negedge clk) begin
    if (enaA !== '0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write ena=%b cyc=%0d", enaA, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_oh = '0;
        mon_oh[mon_e.bank] = 1'b1;
        if (enaA !== mon_oh || weA !== mon_oh ||
            addrA_ping_pong !== mon_e.addr ||
            diA !== mon_e.data || cyc != mon_e.cyc + 1) begin
          bad++;
          $display("FAIL write ena=%b we=%b addr=%h data=%h cyc=%0d exp ena=%b addr=%h data=%h cyc=%0d",
                   enaA, weA, addrA_ping_pong, diA, cyc,
                   mon_oh, mon_e.addr, mon_e.data, mon_e.cyc + 1);
        end
      end
    end
  end

  task automatic pulse_release;
    rd_buf_release = 1'b1;
    if (m_full[m_rd]) begin
      m_full[m_rd] = 1'b0;
      m_rd = ~m_rd;
    end else begin
      m_err_rel = 1'b1;
    end
    @(posedge clk); #1;
    rd_buf_release = 1'b0;
  endtask

  task automatic drain;
    while (m_full != 2'b00) begin
      pulse_release();
      @(negedge clk);
      total++;
      if (buf_full !== m_full) begin
        bad++;
        $display("FAIL drain_buf_full got=%b exp=%b", buf_full, m_full);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send_cfg(input int w, input int f);
    int g;
    g = 0;
    while (!cfg_ready && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 300) begin
      total++; bad++;
      $display("FAIL cfg_ready_timeout got=0 exp=1");
    end
    cfg_words_per_bank = AW'(w);
    cfg_num_fills = FW'(f);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // mode 0: always valid, 1: alternate, 2: random gaps
  task automatic send_fill(input int words, input int mode, input bit chk_ptr);
    int n, k, guard, ec;
    bit v;
    int acc_c[$];
    int acc_b[$];
    wr_t e;
    logic [AW-1:0] p;
    n = words * NB;
    k = 0;
    guard = 0;
    while (k < n) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2) == 0;
        default: v = $urandom_range(0, 2) != 0;
      endcase
      act_stream_valid = v;
      act_stream_data = {$urandom, $urandom};
      act_stream_last = (k == n - 1);
      @(negedge clk);
      if (chk_ptr) begin
        for (int b = 0; b < NB; b++) begin
          ec = 0;
          for (int i = 0; i < acc_c.size(); i++)
            if (acc_b[i] == b && acc_c[i] <= cyc - 2) ec++;
          p = write_addr_pingpong_data[b*AW +: AW];
          total++;
          if (p !== {m_pp, ec[AW-2:0]}) begin
            bad++;
            $display("FAIL ptr_lag bank=%0d got=%h exp=%h", b, p, {m_pp, ec[AW-2:0]});
          end
        end
      end
      if (v && act_stream_ready) begin
        e.bank = k % NB;
        e.addr = {AW'(k / NB)} << 1 | AW'(m_pp);
        e.data = act_stream_data;
        e.cyc  = cyc;
        exp_q.push_back(e);
        acc_c.push_back(cyc);
        acc_b.push_back(k % NB);
        k++;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        total++; bad++;
        $display("FAIL fill_timeout got=%0d exp=%0d beats", k, n);
        break;
      end
    end
    act_stream_valid = 1'b0;
    act_stream_last = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    m_full[m_pp] = 1'b1;
    m_pp = ~m_pp;
    total++;
    if (buf_full !== m_full) begin
      bad++;
      $display("FAIL commit_buf_full got=%b exp=%b", buf_full, m_full);
    end
    for (int b = 0; b < NB; b++) begin
      p = write_addr_pingpong_data[b*AW +: AW];
      total++;
      if (p !== {m_pp, {(AW-1){1'b0}}}) begin
        bad++;
        $display("FAIL commit_ptr bank=%0d got=%h exp=%h", b, p, {m_pp, {(AW-1){1'b0}}});
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL writes_pending got=%0d exp=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({cfg_ready, act_stream_ready, enaA, weA, buf_full,
         err_cfg, err_release} !== {2'b10, {(2*NB+4){1'b0}}}) begin
      bad++;
      $display("FAIL reset_ctrl got=%b%b %b %b %b %b%b exp=10 0 0 00 00",
               cfg_ready, act_stream_ready, enaA, weA, buf_full,
               err_cfg, err_release);
    end
    total++;
    if ({addrA_ping_pong, diA, write_addr_pingpong_data} !== '0) begin
      bad++;
      $display("FAIL reset_data got addr=%h ptr=%h exp=0", addrA_ping_pong,
               write_addr_pingpong_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
  endtask

  task automatic test_basic;
    send_cfg(2, 1);
    send_fill(2, 0, 0);
    total++;
    if (cfg_ready !== 1'b1 || act_stream_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle got cfg_ready=%b ready=%b exp 1 0",
               cfg_ready, act_stream_ready);
    end
  endtask

  task automatic test_release_err;
    drain();
    for (int i = 0; i < 2; i++) begin
      pulse_release();
      @(negedge clk);
      total++;
      if (err_release !== 1'b1 || buf_full !== 2'b00) begin
        bad++;
        $display("FAIL release_err got err=%b full=%b exp err=1 full=00",
                 err_release, buf_full);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cfg_err;
    int bw[4] = '{0, WD + 1, 1, 1};
    int bf[4] = '{1, 1, 0, MF + 1};
    for (int i = 0; i < 4; i++) begin
      send_cfg(bw[i], bf[i]);
      @(negedge clk);
      total++;
      if (err_cfg !== 1'b1 || cfg_ready !== 1'b1) begin
        bad++;
        $display("FAIL cfg_err case=%0d got err=%b rdy=%b exp err=1 rdy=1",
                 i, err_cfg, cfg_ready);
      end
      @(posedge clk); #1;
    end
    drain();
    send_cfg(1, 1);
    @(negedge clk);
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL cfg_legal_accept got rdy=%b exp=0", cfg_ready);
    end
    @(posedge clk); #1;
    send_fill(1, 0, 0);
  endtask

  task automatic test_multi_fill;
    drain();
    send_cfg(2, 3);
    send_fill(2, 0, 0);
    send_fill(2, 0, 0);
    act_stream_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (act_stream_ready !== 1'b0 || buf_full !== 2'b11) begin
        bad++;
        $display("FAIL stall got ready=%b full=%b exp ready=0 full=11",
                 act_stream_ready, buf_full);
      end
      @(posedge clk); #1;
    end
    act_stream_valid = 1'b0;
    pulse_release();
    @(negedge clk);
    total++;
    if (act_stream_ready !== 1'b1 || buf_full !== m_full) begin
      bad++;
      $display("FAIL unstall got ready=%b full=%b exp ready=1 full=%b",
               act_stream_ready, buf_full, m_full);
    end
    @(posedge clk); #1;
    send_fill(2, 0, 0);
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL multi_idle got=%b exp=1", cfg_ready);
    end
  endtask

  task automatic test_valid_toggle;
    drain();
    send_cfg(2, 1);
    send_fill(2, 1, 1);
  endtask

  task automatic test_random;
    int w, f;
    drain();
    for (int i = 0; i < 5; i++) begin
      w = $urandom_range(1, 4);
      f = $urandom_range(1, 3);
      send_cfg(w, f);
      for (int j = 0; j < f; j++) begin
        if (m_full[m_pp]) pulse_release();
        send_fill(w, 2, (i == 0));
        total++;
        if (cfg_ready !== (j == f - 1)) begin
          bad++;
          $display("FAIL rand_cfg_ready cfg=%0d fill=%0d got=%b exp=%b",
                   i, j, cfg_ready, (j == f - 1));
        end
        if ($urandom_range(0, 1) == 1 && m_full != 2'b00) pulse_release();
      end
    end
  endtask

  task automatic test_reset_mid;
    int k;
    int guard;
    wr_t e;
    drain();
    send_cfg(2, 1);
    k = 0;
    guard = 0;
    while (k < 2 && guard < 50) begin
      act_stream_valid = 1'b1;
      act_stream_data = {$urandom, $urandom};
      @(negedge clk);
      if (act_stream_ready) begin
        e.bank = k;
        e.addr = AW'(m_pp);
        e.data = act_stream_data;
        e.cyc  = cyc;
        exp_q.push_back(e);
        k++;
      end
      @(posedge clk); #1;
      guard++;
    end
    act_stream_data = {$urandom, $urandom};
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (act_stream_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_inflight got ready=%b exp=1", act_stream_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    act_stream_valid = 1'b0;
    m_pp = 1'b0; m_rd = 1'b0; m_full = 2'b00; m_err_rel = 1'b0;
    @(negedge clk);
    total++;
    if ({cfg_ready, act_stream_ready, enaA, weA, buf_full,
         err_cfg, err_release} !== {2'b10, {(2*NB+4){1'b0}}}) begin
      bad++;
      $display("FAIL midreset_ctrl got rdy=%b ena=%b full=%b errs=%b%b exp rdy=1 rest 0",
               cfg_ready, enaA, buf_full, err_cfg, err_release);
    end
    total++;
    if ({addrA_ping_pong, diA, write_addr_pingpong_data} !== '0) begin
      bad++;
      $display("FAIL midreset_data got addr=%h ptr=%h exp=0",
               addrA_ping_pong, write_addr_pingpong_data);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL midreset_pending got=%0d exp=0", exp_q.size());
    end
    @(posedge clk); #1;
    @(negedge clk);
`ifdef IWRITE_LAST_CHECK_EN
    total++;
    if (err_last !== 1'b0) begin
      bad++;
      $display("FAIL err_last got=%b exp=0", err_last);
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad = 0;
    m_pp = 1'b0; m_rd = 1'b0; m_full = 2'b00; m_err_rel = 1'b0;
    test_reset();
    test_basic();
    test_release_err();
    test_cfg_err();
    test_multi_fill();
    test_valid_toggle();
    test_random();
`ifdef IWRITE_LAST_CHECK_EN
    total++;
    if (err_last !== 1'b0) begin
      bad++;
      $display("FAIL err_last_clean got=%b exp=0", err_last);
    end
`endif
    total++;
    if (err_release !== m_err_rel) begin
      bad++;
      $display("FAIL err_release_sticky got=%b exp=%b", err_release, m_err_rel);
    end
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
